// File: rtl/reg_file_mp.sv
// Parametrised 2-read/1-write register file with write-first bypass, registered reads and a busy scoreboard.
// Optional feature: define ZERO_REG_EN to hardwire register 0 to zero (no writes, no bypass, no reserve).
module reg_file_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_en,
  input  logic                   I_we,
  input  logic [ADDR_W-1:0]      I_selD,
  input  logic [DATA_W-1:0]      I_dataD,
  input  logic                   I_re,
  input  logic [ADDR_W-1:0]      I_selA,
  input  logic [ADDR_W-1:0]      I_selB,
  input  logic                   I_rsv,
  input  logic [ADDR_W-1:0]      I_selR,
  output logic [DATA_W-1:0]      O_dataA,
  output logic [DATA_W-1:0]      O_dataB,
  output logic                   O_valid,
  output logic                   O_hazA,
  output logic                   O_hazB,
  output logic [(2**ADDR_W)-1:0] O_busy
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_next_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic              haz_a_s;
  logic              haz_b_s;
  logic              wr_ok_s;
  logic              rsv_ok_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] sel);
    return ZERO_REG & (sel == {ADDR_W{1'b0}});
  endfunction

  // Write-first read value: hardwired zero, then in-flight write data, then stored contents
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] sel);
    if (is_zero(sel)) begin
      return {DATA_W{1'b0}};
    end else if (I_we && (I_selD == sel)) begin
      return I_dataD;
    end else begin
      return regs_r[sel];
    end
  endfunction

  // Qualified requests, bypassed read data, hazard flags and next scoreboard
  always_comb begin
    wr_ok_s     = I_en & I_we & ~is_zero(I_selD);
    rsv_ok_s    = I_en & I_rsv & ~is_zero(I_selR);
    rd_a_s      = read_val(I_selA);
    rd_b_s      = read_val(I_selB);
    haz_a_s     = busy_r[I_selA] & ~(I_we & (I_selD == I_selA));
    haz_b_s     = busy_r[I_selB] & ~(I_we & (I_selD == I_selB));
    busy_next_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      // A new reservation outranks the clear from a completing write
      if (rsv_ok_s && (I_selR == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (wr_ok_s && (I_selD == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Register storage
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok_s && (I_selD == ADDR_W'(i))) begin
          regs_r[i] <= I_dataD;
        end
      end
    end
  end

  // Scoreboard and registered read outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      busy_r  <= {DEPTH{1'b0}};
      O_dataA <= {DATA_W{1'b0}};
      O_dataB <= {DATA_W{1'b0}};
      O_valid <= 1'b0;
      O_hazA  <= 1'b0;
      O_hazB  <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      if (I_en && I_re) begin
        O_dataA <= rd_a_s;
        O_dataB <= rd_b_s;
        O_hazA  <= haz_a_s;
        O_hazB  <= haz_b_s;
        O_valid <= 1'b1;
      end else begin
        O_valid <= 1'b0;
      end
    end
  end

  assign O_busy = busy_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_file_mp;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          I_clk = 1'b0;
  logic          I_rst_n;
  logic          I_en, I_we, I_re, I_rsv;
  logic [AW-1:0] I_selD, I_selA, I_selB, I_selR;
  logic [DW-1:0] I_dataD;
  logic [DW-1:0] O_dataA, O_dataB;
  logic          O_valid, O_hazA, O_hazB;
  logic [N-1:0]  O_busy;

  always #5 I_clk = ~I_clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we), .I_selD(I_selD),
    .I_dataD(I_dataD), .I_re(I_re), .I_selA(I_selA), .I_selB(I_selB), .I_rsv(I_rsv),
    .I_selR(I_selR), .O_dataA(O_dataA), .O_dataB(O_dataB), .O_valid(O_valid),
    .O_hazA(O_hazA), .O_hazB(O_hazB), .O_busy(O_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain array of values, a busy bit per register and the last read result
  logic [DW-1:0] m_regs [N];
  logic [N-1:0]  m_busy;
  logic [DW-1:0] m_da, m_db;
  logic          m_valid, m_ha, m_hb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_busy = '0; m_da = '0; m_db = '0; m_valid = 1'b0; m_ha = 1'b0; m_hb = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] sel);
    if (ZR && sel == 3'd0) return 16'h0000;
    if (I_we && I_selD == sel) return I_dataD;
    return m_regs[sel];
  endfunction

  task automatic m_step();
    if (I_en) begin
      if (I_re) begin
        m_da    = m_read(I_selA);
        m_db    = m_read(I_selB);
        m_ha    = m_busy[I_selA] && !(I_we && I_selD == I_selA);
        m_hb    = m_busy[I_selB] && !(I_we && I_selD == I_selB);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (I_we && !(ZR && I_selD == 3'd0)) m_regs[I_selD] = I_dataD;
      if (I_we) m_busy[I_selD] = 1'b0;
      if (I_rsv && !(ZR && I_selR == 3'd0)) m_busy[I_selR] = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("dataA", 64'(O_dataA), 64'(m_da));
    check("dataB", 64'(O_dataB), 64'(m_db));
    check("valid", 64'(O_valid), 64'(m_valid));
    check("hazA",  64'(O_hazA),  64'(m_ha));
    check("hazB",  64'(O_hazB),  64'(m_hb));
    check("busy",  64'(O_busy),  64'(m_busy));
  endtask

  // Drive one cycle's requests at a falling edge, advance the model, compare at the next falling edge
  task automatic drive(input logic en, input logic we, input logic [AW-1:0] sd, input logic [DW-1:0] dd,
                       input logic re, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                       input logic rsv, input logic [AW-1:0] sr);
    I_en = en; I_we = we; I_selD = sd; I_dataD = dd; I_re = re;
    I_selA = sa; I_selB = sb; I_rsv = rsv; I_selR = sr;
    m_step();
    @(negedge I_clk);
    compare_all();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    I_rst_n = 1'b0;
    I_en = 1'b0; I_we = 1'b0; I_re = 1'b0; I_rsv = 1'b0;
    I_selD = '0; I_selA = '0; I_selB = '0; I_selR = '0; I_dataD = '0;
    m_reset();
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
    compare_all();
    check("rst_busy", 64'(O_busy), 64'h0);
    check("rst_valid", 64'(O_valid), 64'h0);

    // Write then read
    drive(1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd2, 1'b0, 3'd0);
    check("wr_rd_A", 64'(O_dataA), 64'hBEEF);
    check("wr_rd_B", 64'(O_dataB), 64'h0000);
    check("wr_rd_valid", 64'(O_valid), 64'h1);
    idle();
    check("valid_pulse", 64'(O_valid), 64'h0);

    // Bypass on both ports
    drive(1'b1, 1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 3'd4, 16'hA5A5, 1'b1, 3'd4, 3'd4, 1'b0, 3'd0);
    check("bypass_A", 64'(O_dataA), 64'hA5A5);
    check("bypass_B", 64'(O_dataB), 64'hA5A5);
    check("bypass_haz", 64'(O_hazA), 64'h0);

    // Scoreboard
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd6);
    check("rsv_busy6", 64'(O_busy[6]), 64'h1);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd1, 1'b0, 3'd0);
    check("rsv_hazA", 64'(O_hazA), 64'h1);
    check("rsv_hazB", 64'(O_hazB), 64'h0);
    drive(1'b1, 1'b1, 3'd6, 16'h0042, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    check("wr_clr_busy6", 64'(O_busy[6]), 64'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 1'b0, 3'd0);
    check("clr_data", 64'(O_dataA), 64'h0042);
    check("clr_haz", 64'(O_hazA), 64'h0);
    drive(1'b1, 1'b1, 3'd6, 16'h0077, 1'b0, 3'd0, 3'd0, 1'b1, 3'd6);
    check("rsv_wins", 64'(O_busy[6]), 64'h1);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 1'b1, 3'd6);
    check("rsv_again_data", 64'(O_dataA), 64'h0077);

    // Enable gating
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, 3'd6, 3'd6, 1'b1, 3'd5);
    check("en0_valid", 64'(O_valid), 64'h0);
    check("en0_hold", 64'(O_dataA), 64'hBEEF);
    check("en0_busy5", 64'(O_busy[5]), 64'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd0, 1'b0, 3'd0);
    check("en0_nowrite", 64'(O_dataA), 64'hBEEF);

    // Register 0 behaviour
    drive(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
`ifdef ZERO_REG_EN
    check("r0_data", 64'(O_dataA), 64'h0000);
    check("r0_haz", 64'(O_hazA), 64'h0);
    check("r0_busy", 64'(O_busy[0]), 64'h0);
`else
    check("r0_data", 64'(O_dataA), 64'hFFFF);
    check("r0_haz", 64'(O_hazA), 64'h1);
    check("r0_busy", 64'(O_busy[0]), 64'h1);
`endif

    // Asynchronous reset in the middle of a cycle
    drive(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 1'b0, 3'd0);
    check("pre_rst_data", 64'(O_dataA), 64'h1234);
    check("pre_rst_haz", 64'(O_hazA), 64'h1);
    #2 I_rst_n = 1'b0;
    #1;
    check("rst_dataA", 64'(O_dataA), 64'h0);
    check("rst_dataB", 64'(O_dataB), 64'h0);
    check("rst_valid_mid", 64'(O_valid), 64'h0);
    check("rst_hazA", 64'(O_hazA), 64'h0);
    check("rst_busy_mid", 64'(O_busy), 64'h0);
    m_reset();
    @(negedge I_clk);
    I_rst_n = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 1'b0, 3'd0);
    check("post_rst_r3", 64'(O_dataA), 64'h0000);
    check("post_rst_haz", 64'(O_hazA), 64'h0);
    check("post_rst_valid", 64'(O_valid), 64'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
            DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
            AW'($urandom_range(0, N - 1)), 1'($urandom_range(0, 2) == 0),
            AW'($urandom_range(0, N - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
